key_press_detector: RTL and testbench

//  Front-end for the two active-low push buttons of the watch/stopwatch top level.

---
 rtl/key_press_detector.sv | 221 ++++++++++++++++++++++
 tb/tb_key_press_detector.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_detector.sv
// -----------------------------------------------------------------------------
// key_press_detector
//
// Front-end for the two active-low push buttons of the watch/stopwatch top
// level. Each raw pin is synchronised, debounced and classified into
// single-cycle events: short press, long press, and a chord when both keys
// are held together. All outputs come straight from flops.
//
// Parameters
//   DEBOUNCE_CYC  stable cycles needed before a level change is accepted
//   LONG_CYC      debounced hold cycles that turn a press into a long press
//
// Ports
//   clk            in   system clock
//   rst_n          in   synchronous reset, active-low
//   i_key_1_n      in   raw key 1, asynchronous, 0 = pressed
//   i_key_2_n      in   raw key 2, asynchronous, 0 = pressed
//   o_key_1        out  debounced level of key 1, 1 = pressed
//   o_key_2        out  debounced level of key 2, 1 = pressed
//   o_key_1_short  out  pulse: key 1 released before LONG_CYC, no chord
//   o_key_1_long   out  pulse: key 1 held LONG_CYC cycles, no chord
//   o_key_2_short  out  pulse: key 2 released before LONG_CYC, no chord
//   o_key_2_long   out  pulse: key 2 held LONG_CYC cycles, no chord
//   o_chord        out  pulse: both debounced levels became 1 together
// -----------------------------------------------------------------------------
module key_press_detector #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned LONG_CYC     = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_1_n,
    input  logic i_key_2_n,
    output logic o_key_1,
    output logic o_key_2,
    output logic o_key_1_short,
    output logic o_key_1_long,
    output logic o_key_2_short,
    output logic o_key_2_long,
    output logic o_chord
);

    localparam int unsigned NKEYS  = 2;
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC);

    // Debounce counter terminal value; key toggles when it is reached.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    // Hold count one short of the terminal value: the next increment would
    // reach LONG_CYC-1, so the long pulse is registered in that same cycle.
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYC - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    // Parameter sanity check at elaboration.
    if (DEBOUNCE_CYC < 2 || LONG_CYC < 2) begin : g_param_check
        $error("key_press_detector: DEBOUNCE_CYC and LONG_CYC must both be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [NKEYS-1:0] w_pin_n;
    logic [NKEYS-1:0] r_sync1;
    logic [NKEYS-1:0] r_sync2;
    logic [NKEYS-1:0] w_raw;
    logic [NKEYS-1:0] w_key;
    logic [NKEYS-1:0] w_short;
    logic [NKEYS-1:0] w_long;
    logic             w_both;
    logic             w_none;
    logic             r_chord_flag;
    logic             r_chord;

    assign w_pin_n = {i_key_2_n, i_key_1_n};

    // Two-flop synchroniser; reset value is the released (high) pin level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_pin_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw = ~r_sync2;

    assign w_both = w_key[0] & w_key[1];
    assign w_none = ~(w_key[0] | w_key[1]);

    // Chord flag: set on the first cycle both keys are down, held until both
    // keys are up again. The pulse fires only on the setting cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chord_flag <= 1'b0;
            r_chord      <= 1'b0;
        end else begin
            r_chord <= w_both & ~r_chord_flag;
            if (w_none) begin
                r_chord_flag <= 1'b0;
            end else if (w_both) begin
                r_chord_flag <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        logic [DB_W-1:0]   r_db_cnt;
        logic              r_key;
        state_t            r_state;
        state_t            w_state_nxt;
        logic [HOLD_W-1:0] r_hold;
        logic [HOLD_W-1:0] w_hold_nxt;
        logic              w_short_nxt;
        logic              w_long_nxt;
        logic              r_short;
        logic              r_long;

        // Debounce: count consecutive cycles the synchronised level disagrees
        // with the accepted level; any agreement restarts the count.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_db_cnt <= '0;
                r_key    <= 1'b0;
            end else if (w_raw[k] != r_key) begin
                if (r_db_cnt == DB_LAST) begin
                    r_key    <= ~r_key;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end

        // Press FSM state register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_hold  <= w_hold_nxt;
            end
        end

        // Press FSM next state; the hold counter saturates at LONG_CYC-1.
        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;
            case (r_state)
                ST_IDLE: begin
                    if (r_key) begin
                        w_state_nxt = ST_PRESSED;
                        w_hold_nxt  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (!r_key) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_hold == HOLD_PRE) begin
                        w_state_nxt = ST_HELD;
                        w_hold_nxt  = HOLD_LAST;
                    end else begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!r_key) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Press FSM outputs: only PRESSED can classify, and a chord mutes it.
        always_comb begin
            w_short_nxt = 1'b0;
            w_long_nxt  = 1'b0;
            if (r_state == ST_PRESSED && !r_chord_flag) begin
                if (!r_key) begin
                    w_short_nxt = 1'b1;
                end else if (r_hold == HOLD_PRE) begin
                    w_long_nxt = 1'b1;
                end
            end
        end

        // Event pulse registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_short <= 1'b0;
                r_long  <= 1'b0;
            end else begin
                r_short <= w_short_nxt;
                r_long  <= w_long_nxt;
            end
        end

        assign w_key[k]   = r_key;
        assign w_short[k] = r_short;
        assign w_long[k]  = r_long;
    end

    assign o_key_1       = w_key[0];
    assign o_key_2       = w_key[1];
    assign o_key_1_short = w_short[0];
    assign o_key_1_long  = w_long[0];
    assign o_key_2_short = w_short[1];
    assign o_key_2_long  = w_long[1];
    assign o_chord       = r_chord;

endmodule

// File: tb/tb_key_press_detector.sv
// -----------------------------------------------------------------------------
// tb_key_press_detector
//
// Bench for key_press_detector with DEBOUNCE_CYC=4, LONG_CYC=20. A cycle-level
// reference built from the behavioural rules runs alongside every clock edge;
// scenario tables and hand-written sequences check event counts and latencies.
// -----------------------------------------------------------------------------
module tb_key_press_detector;

    localparam int DB = 4;
    localparam int LC = 20;
    localparam int NSCEN = 12;
    localparam int SCEN_LEN = 120;

    logic clk = 1'b0;
    logic rst_n;
    logic key_1_n;
    logic key_2_n;
    logic key_1;
    logic key_2;
    logic key_1_short;
    logic key_1_long;
    logic key_2_short;
    logic key_2_long;
    logic chord;

    always #5 clk = ~clk;

    key_press_detector #(
        .DEBOUNCE_CYC (DB),
        .LONG_CYC     (LC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_key_1_n     (key_1_n),
        .i_key_2_n     (key_2_n),
        .o_key_1       (key_1),
        .o_key_2       (key_2),
        .o_key_1_short (key_1_short),
        .o_key_1_long  (key_1_long),
        .o_key_2_short (key_2_short),
        .o_key_2_long  (key_2_long),
        .o_chord       (chord)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference state
    bit m_lvl    [2];
    bit m_flag;
    bit m_active [2];
    bit m_done   [2];
    int m_t      [2];
    bit m_hist   [2][DB+1];
    bit e_short  [2];
    bit e_long   [2];
    bit e_chord;

    // Observations of the DUT
    int n_s1, n_l1, n_s2, n_l2, n_ch, n_k2_high;
    int t_rise1, t_rise2, t_fall1, t_long1, t_short1, t_chord;
    bit prev_k1, prev_k2;

    typedef struct {
        int p1s; int p1l; int p2s; int p2l;
        int s1;  int l1;  int s2;  int l2; int ch;
    } scen_t;

    scen_t tab [NSCEN];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference: one clock edge. Pin samples of 0 that persist for DB
    // consecutive sync outputs flip the level; presses are classified by
    // how long the level stays high, muted while a chord is in progress.
    task automatic model_edge(input logic rst_s, input logic p1, input logic p2);
        bit pin [2];
        bit pl  [2];
        bit win_match;
        pin[0] = p1;
        pin[1] = p2;
        e_chord = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e_short[k] = 1'b0;
            e_long[k]  = 1'b0;
        end
        if (!rst_s) begin
            m_flag = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_lvl[k]    = 1'b0;
                m_active[k] = 1'b0;
                m_done[k]   = 1'b0;
                m_t[k]      = 0;
                for (int i = 0; i <= DB; i++) m_hist[k][i] = 1'b1;
            end
            return;
        end
        pl[0] = m_lvl[0];
        pl[1] = m_lvl[1];
        e_chord = pl[0] && pl[1] && !m_flag;
        for (int k = 0; k < 2; k++) begin
            if (!m_active[k]) begin
                if (pl[k]) begin
                    m_active[k] = 1'b1;
                    m_done[k]   = 1'b0;
                    m_t[k]      = cyc - 1;
                end
            end else if (!pl[k]) begin
                if (!m_done[k] && !m_flag) e_short[k] = 1'b1;
                m_active[k] = 1'b0;
            end else if (!m_done[k] && (cyc - m_t[k]) == LC) begin
                if (!m_flag) e_long[k] = 1'b1;
                m_done[k] = 1'b1;
            end
        end
        if (!pl[0] && !pl[1]) m_flag = 1'b0;
        else if (pl[0] && pl[1]) m_flag = 1'b1;
        for (int k = 0; k < 2; k++) begin
            // A pin sample equal to the level means the active-high raw
            // value disagrees with it.
            win_match = 1'b1;
            for (int i = 0; i < DB; i++) begin
                if (m_hist[k][i] != m_lvl[k]) win_match = 1'b0;
            end
            if (win_match) m_lvl[k] = !m_lvl[k];
            for (int i = 0; i < DB; i++) m_hist[k][i] = m_hist[k][i+1];
            m_hist[k][DB] = pin[k];
        end
    endtask

    task automatic clear_counts();
        n_s1 = 0; n_l1 = 0; n_s2 = 0; n_l2 = 0; n_ch = 0; n_k2_high = 0;
        t_rise1 = -1000; t_rise2 = -1000; t_fall1 = -1000;
        t_long1 = -1000; t_short1 = -1000; t_chord = -1000;
    endtask

    // Advance one clock, update the reference, compare on the falling edge.
    task automatic step();
        logic [6:0] act_v;
        logic [6:0] exp_v;
        @(posedge clk);
        cyc++;
        model_edge(rst_n, key_1_n, key_2_n);
        @(negedge clk);
        act_v = {key_1, key_2, key_1_short, key_1_long, key_2_short, key_2_long, chord};
        exp_v = {m_lvl[0], m_lvl[1], e_short[0], e_long[0], e_short[1], e_long[1], e_chord};
        check("cycle_outputs", int'(act_v), int'(exp_v));
        if (key_1_short) begin n_s1++; t_short1 = cyc; end
        if (key_1_long)  begin n_l1++; t_long1 = cyc; end
        if (key_2_short) n_s2++;
        if (key_2_long)  n_l2++;
        if (chord)       begin n_ch++; t_chord = cyc; end
        if (key_2)       n_k2_high++;
        if (key_1 && !prev_k1) t_rise1 = cyc;
        if (!key_1 && prev_k1) t_fall1 = cyc;
        if (key_2 && !prev_k2) t_rise2 = cyc;
        prev_k1 = key_1;
        prev_k2 = key_2;
    endtask

    initial begin
        int p;
        int r0;
        int rem [2];
        bit lvl_n [2];

        //          p1s p1l p2s p2l | s1 l1 s2 l2 ch
        tab[0]  = '{0,  10, -1, 0,    1, 0, 0, 0, 0};
        tab[1]  = '{0,  40, -1, 0,    0, 1, 0, 0, 0};
        tab[2]  = '{-1, 0,  0,  12,   0, 0, 1, 0, 0};
        tab[3]  = '{-1, 0,  0,  30,   0, 0, 0, 1, 0};
        tab[4]  = '{0,  50, 5,  40,   0, 0, 0, 0, 1};
        tab[5]  = '{0,  30, 0,  30,   0, 0, 0, 0, 1};
        tab[6]  = '{0,  19, -1, 0,    1, 0, 0, 0, 0};
        tab[7]  = '{0,  20, -1, 0,    0, 1, 0, 0, 0};
        tab[8]  = '{0,  3,  -1, 0,    0, 0, 0, 0, 0};
        tab[9]  = '{0,  4,  -1, 0,    1, 0, 0, 0, 0};
        tab[10] = '{0,  60, 30, 20,   0, 1, 0, 0, 1};
        tab[11] = '{0,  8,  20, 8,    1, 0, 1, 0, 0};

        prev_k1 = 1'b0;
        prev_k2 = 1'b0;
        clear_counts();
        rst_n   = 1'b0;
        key_1_n = 1'b1;
        key_2_n = 1'b1;
        repeat (3) step();
        check("reset_key_1", int'(key_1), 0);
        check("reset_chord", int'(chord), 0);
        rst_n = 1'b1;
        repeat (10) step();

        // Scenario table
        for (int s = 0; s < NSCEN; s++) begin
            clear_counts();
            for (int c = 0; c < SCEN_LEN; c++) begin
                key_1_n = !(tab[s].p1s >= 0 && c >= tab[s].p1s && c < tab[s].p1s + tab[s].p1l);
                key_2_n = !(tab[s].p2s >= 0 && c >= tab[s].p2s && c < tab[s].p2s + tab[s].p2l);
                step();
            end
            check($sformatf("scen%0d_short1", s), n_s1, tab[s].s1);
            check($sformatf("scen%0d_long1",  s), n_l1, tab[s].l1);
            check($sformatf("scen%0d_short2", s), n_s2, tab[s].s2);
            check($sformatf("scen%0d_long2",  s), n_l2, tab[s].l2);
            check($sformatf("scen%0d_chord",  s), n_ch, tab[s].ch);
        end

        // Short press latency: level rises DB+2 after the pin, pulse 1 after fall
        clear_counts();
        key_1_n = 1'b0;
        p = cyc;
        repeat (10) step();
        key_1_n = 1'b1;
        repeat (30) step();
        check("short_rise_latency", t_rise1 - p, DB + 2);
        check("short_pulse_after_fall", t_short1 - t_fall1, 1);
        check("short_count", n_s1, 1);
        check("short_no_long", n_l1, 0);

        // Long press latency: pulse LC cycles after the level rises
        clear_counts();
        key_1_n = 1'b0;
        p = cyc;
        repeat (40) step();
        key_1_n = 1'b1;
        repeat (30) step();
        check("long_rise_latency", t_rise1 - p, DB + 2);
        check("long_pulse_latency", t_long1 - t_rise1, LC);
        check("long_count", n_l1, 1);
        check("long_no_short", n_s1, 0);

        // Repeated 3-cycle glitches on key 2 never get through
        clear_counts();
        for (int r = 0; r < 10; r++) begin
            key_2_n = 1'b0;
            repeat (3) step();
            key_2_n = 1'b1;
            repeat (2) step();
        end
        repeat (10) step();
        check("glitch_key2_level", n_k2_high, 0);
        check("glitch_pulses", n_s2 + n_l2 + n_ch, 0);

        // Simultaneous press, then key 2 released and re-pressed under the chord
        clear_counts();
        key_1_n = 1'b0;
        key_2_n = 1'b0;
        repeat (40) step();
        check("simul_rise_align", t_rise2 - t_rise1, 0);
        check("simul_chord_latency", t_chord - t_rise1, 1);
        key_2_n = 1'b1;
        repeat (15) step();
        key_2_n = 1'b0;
        repeat (30) step();
        key_1_n = 1'b1;
        key_2_n = 1'b1;
        repeat (30) step();
        check("simul_chord_count", n_ch, 1);
        check("simul_no_short_long", n_s1 + n_l1 + n_s2 + n_l2, 0);

        // Reset mid-press at hold count 10, key kept down through reset
        clear_counts();
        key_1_n = 1'b0;
        repeat (DB + 2 + 11) step();
        rst_n = 1'b0;
        step();
        r0 = cyc;
        check("midrst_key_1", int'(key_1), 0);
        check("midrst_pulses", int'({key_1_short, key_1_long, chord}), 0);
        rst_n = 1'b1;
        clear_counts();
        repeat (40) step();
        check("midrst_rise_latency", t_rise1 - r0, DB + 2);
        check("midrst_long_latency", t_long1 - t_rise1, LC);
        check("midrst_long_count", n_l1, 1);
        key_1_n = 1'b1;
        repeat (20) step();
        check("midrst_no_short", n_s1, 0);

        // Random pin activity with occasional resets, checked every cycle
        rem[0] = 5;
        rem[1] = 9;
        lvl_n[0] = 1'b1;
        lvl_n[1] = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (rem[k] == 0) begin
                    lvl_n[k] = !lvl_n[k];
                    case ($urandom_range(0, 2))
                        0:       rem[k] = int'($urandom_range(1, 5));
                        1:       rem[k] = int'($urandom_range(6, 25));
                        default: rem[k] = int'($urandom_range(20, 60));
                    endcase
                end
                rem[k]--;
            end
            key_1_n = lvl_n[0];
            key_2_n = lvl_n[1];
            rst_n   = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n   = 1'b1;
        key_1_n = 1'b1;
        key_2_n = 1'b1;
        repeat (100) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
